fifo_wr_arb: RTL and testbench
==============================

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 Parameter Dsize, default 8: data width per requester and toward the FIFO write port.
REQ-002 Parameter NREQ, default 4: number of requesters; legal range 2..16.
REQ-003 Parameter BURST, default 4: maximum beats per grant; legal range 1..256.
REQ-004 wclk  input  1  sole clock; all state updates on its rising edge.
REQ-005 w_rst  input  1  asynchronous, active-high reset.
REQ-006 req_valid  input  NREQ  bit i: requester i presents a beat.
REQ-007 req_data  input  NREQ*Dsize  requester i data in bits [i*Dsize +: Dsize].
REQ-008 req_ready  output  NREQ  bit i: requester i beat accepted this cycle.
REQ-009 wfull  input  1  FIFO write-side full flag.
REQ-010 winc  output  1  FIFO write enable.
REQ-011 w_data  output  Dsize  FIFO write data.
REQ-012 grant_id  output  clog2(NREQ)  index of the current owner; valid only while busy=1.
REQ-013 busy  output  1  high when state is GRANT.

Function
REQ-014 The FSM SHALL have exactly two states: IDLE and GRANT.
REQ-015 IDLE->GRANT SHALL occur at the edge where any req_valid is high. The registered owner is the first valid index, searching upward and wrapping, from last_grant+1.
REQ-016 In GRANT, the following SHALL hold combinationally:
  - req_ready[grant_id] = req_valid[grant_id] & ~wfull; all other req_ready bits are 0.
  - winc = req_ready[grant_id].
  - w_data = req_data slice of grant_id.
REQ-017 In IDLE, winc and all req_ready bits SHALL be 0, and w_data SHALL be 0.
REQ-018 A beat counter of clog2(BURST)+1 bits SHALL increment on each transfer (winc=1). It SHALL clear on every grant change and on entry to IDLE.
REQ-019 Release condition: a transfer that makes the count equal BURST, or req_valid[grant_id]=0 in GRANT.
REQ-020 On release, the same edge SHALL re-arbitrate from grant_id+1:
  - if another valid exists, or the owner is still valid after a BURST limit, go to GRANT with the new owner;
  - otherwise go to IDLE.
  - No bubble cycle is inserted.
REQ-021 last_grant SHALL update to the new owner at every grant edge.
REQ-022 wfull=1 SHALL stall: no transfer, counter holds, owner holds, and the valid-low release still applies.
REQ-023 With a single active requester, it SHALL be regranted after each BURST with zero idle cycles between bursts.
REQ-024 Latency: req_valid rising in cycle t from IDLE gives first possible winc in cycle t+1.
REQ-025 The block SHALL never assert winc while wfull=1.

Reset
REQ-026 While w_rst=1, the block SHALL hold:
  - state=IDLE, counter=0, grant_id=0;
  - last_grant=NREQ-1, so the first grant goes to the lowest valid index;
  - busy=0, winc=0, req_ready=0.
REQ-027 A reset asserted mid-burst SHALL abort the burst immediately (asynchronously). No partial-state recovery is required.
REQ-028 Deassertion SHALL take effect at the first wclk edge after w_rst falls; the environment synchronizes deassertion.

Structure
REQ-029 Package fifo_arb_pkg SHALL hold:
  - the state enum (IDLE, GRANT);
  - the default values of Dsize, NREQ and BURST.
REQ-030 Sub-module rr_pick (combinational, parameter NREQ) SHALL take a request vector and a start index, and return found and the index.
REQ-031 rr_pick SHALL be instantiated once inside fifo_wr_arb.

Verification
REQ-032 Reset, then req_valid=4'b0100 held, wfull=0 (NREQ=4, BURST=4):
  - grant_id=2 one cycle later;
  - 4 winc beats, immediate regrant of 2, no idle cycle.
REQ-033 All four requesters valid continuously:
  - grant order 0,1,2,3,0;
  - exactly 4 beats each;
  - winc high every cycle.
REQ-034 Owner 1 drops req_valid after 2 beats while 3 is valid:
  - next edge grant_id=3, counter=0;
  - req_ready[1] is never high after the drop.
REQ-035 wfull=1 for 5 cycles mid-burst:
  - winc=0 and req_ready=0 throughout;
  - counter frozen;
  - the burst completes its remaining beats after wfull falls.
REQ-036 w_rst pulsed while in GRANT with count=2:
  - outputs go to reset values without a clock edge;
  - after release with all valid, the first grant is 0.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg
//   Shared definitions for the FIFO write-side arbiter:
//   - default values for the data width, requester count and burst length
//   - the two-state arbiter state type (IDLE / GRANT)
package fifo_arb_pkg;

  localparam int DSIZE_DEFAULT = 8;
  localparam int NREQ_DEFAULT  = 4;
  localparam int BURST_DEFAULT = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// rr_pick
//   Combinational round-robin search. Starting at i_start and walking upward
//   with wrap-around, returns the first index whose request bit is set.
// Ports:
//   i_req    [NREQ-1:0]          request vector
//   i_start  [clog2(NREQ)-1:0]   first index to examine (must be < NREQ)
//   o_found                      any request bit set
//   o_idx    [clog2(NREQ)-1:0]   winning index (0 when nothing is found)
module rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         i_req,
  input  logic [$clog2(NREQ)-1:0] i_start,
  output logic                    o_found,
  output logic [$clog2(NREQ)-1:0] o_idx
);

  localparam int IW = $clog2(NREQ);

  // Walk the offsets from farthest to nearest so that the last hit written
  // is the one closest to i_start, which is the round-robin winner.
  always_comb begin
    int pos;
    pos     = 0;
    o_found = 1'b0;
    o_idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      pos = int'(i_start) + i;
      if (pos >= NREQ) begin
        pos = pos - NREQ;
      end
      if (i_req[pos]) begin
        o_found = 1'b1;
        o_idx   = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb
//   Round-robin arbiter merging NREQ valid/ready requesters onto a single
//   FIFO write port. A winner owns the port for up to BURST beats, or until
//   it drops its valid, and the next owner is chosen on that same edge.
// Ports:
//   wclk, w_rst                 clock, asynchronous active-high reset
//   req_valid [NREQ]            per-requester beat valid
//   req_data  [NREQ*Dsize]      per-requester data, requester i at [i*Dsize +: Dsize]
//   req_ready [NREQ]            per-requester beat accepted this cycle
//   wfull                       FIFO full, stalls the current owner
//   winc, w_data [Dsize]        FIFO write enable and write data
//   grant_id  [clog2(NREQ)]     current owner, meaningful while busy
//   busy                        an owner holds the port
module fifo_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter int Dsize = DSIZE_DEFAULT,
  parameter int NREQ  = NREQ_DEFAULT,
  parameter int BURST = BURST_DEFAULT
) (
  input  logic                    wclk,
  input  logic                    w_rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*Dsize-1:0]   req_data,
  output logic [NREQ-1:0]         req_ready,
  input  logic                    wfull,
  output logic                    winc,
  output logic [Dsize-1:0]        w_data,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    busy
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(BURST) + 1;
  // A transfer taken while the count sits here is the final beat of a burst.
  localparam logic [CW-1:0] BURST_LAST = CW'(BURST - 1);

  state_t          r_state;
  logic [IW-1:0]   r_owner;
  logic [IW-1:0]   r_last;
  logic [CW-1:0]   r_count;

  logic [IW-1:0]   w_start;
  logic            w_found;
  logic [IW-1:0]   w_pickIdx;
  logic            w_busy;
  logic            w_ownerValid;
  logic            w_xfer;
  logic            w_release;

  // While granted r_last always equals r_owner, so one search starting after
  // r_last serves both the idle pick and the release re-arbitration. Because
  // the search wraps, an owner that is still valid is only re-picked when
  // nobody else is asking.
  assign w_start      = (r_last == IW'(NREQ - 1)) ? '0 : r_last + 1'b1;
  assign w_busy       = (r_state == GRANT);
  assign w_ownerValid = req_valid[r_owner];
  assign w_xfer       = w_busy & w_ownerValid & ~wfull;
  // Owner dropping valid releases even when the FIFO is full.
  assign w_release    = w_busy & ((w_xfer & (r_count == BURST_LAST)) | ~w_ownerValid);

  rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .i_req   (req_valid),
    .i_start (w_start),
    .o_found (w_found),
    .o_idx   (w_pickIdx)
  );

  // Arbiter state: pick an owner from IDLE, count beats while granted, and
  // hand over on release without an idle bubble when anyone is still asking.
  always_ff @(posedge wclk or posedge w_rst) begin
    if (w_rst) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_last  <= IW'(NREQ - 1);
      r_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_count <= '0;
          if (w_found) begin
            r_state <= GRANT;
            r_owner <= w_pickIdx;
            r_last  <= w_pickIdx;
          end
        end
        GRANT: begin
          if (w_release) begin
            r_count <= '0;
            if (w_found) begin
              r_owner <= w_pickIdx;
              r_last  <= w_pickIdx;
            end else begin
              r_state <= IDLE;
            end
          end else if (w_xfer) begin
            r_count <= r_count + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_count <= '0;
        end
      endcase
    end
  end

  // The datapath is a pure mux on the registered owner, so acceptance
  // reacts to valid and wfull within the same cycle.
  always_comb begin
    req_ready = '0;
    winc      = 1'b0;
    w_data    = '0;
    if (w_busy) begin
      req_ready[r_owner] = w_xfer;
      winc               = w_xfer;
      w_data             = req_data[r_owner*Dsize +: Dsize];
    end
  end

  assign busy     = w_busy;
  assign grant_id = r_owner;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb_fifo_wr_arb
//   Self-checking bench for fifo_wr_arb (Dsize=8, NREQ=4, BURST=4). Directed
//   scenarios check the arbitration sequences, the stall and the asynchronous
//   reset; a randomized run checks every output against a behavioural model.
module tb_fifo_wr_arb;

  localparam int DS = 8;
  localparam int NR = 4;
  localparam int BU = 4;

  logic          wclk;
  logic          w_rst;
  logic [NR-1:0] req_valid;
  logic [NR*DS-1:0] req_data;
  logic [NR-1:0] req_ready;
  logic          wfull;
  logic          winc;
  logic [DS-1:0] w_data;
  logic [1:0]    grant_id;
  logic          busy;

  int total = 0;
  int bad   = 0;

  // Behavioural model: who owns the port and how many beats it has moved.
  bit mBusy;
  int mOwner;
  int mLast;
  int mBeats;

  logic [NR-1:0] expReady;
  logic          expWinc;
  logic [DS-1:0] expData;
  logic          expBusy;

  fifo_wr_arb #(
    .Dsize (DS),
    .NREQ  (NR),
    .BURST (BU)
  ) dut (
    .wclk      (wclk),
    .w_rst     (w_rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wfull     (wfull),
    .winc      (winc),
    .w_data    (w_data),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  // First asking requester at or after 'from', wrapping; -1 if none.
  function automatic int firstValid(input logic [NR-1:0] v, input int from);
    for (int k = 0; k < NR; k++) begin
      if (v[(from + k) % NR]) return (from + k) % NR;
    end
    return -1;
  endfunction

  task automatic modelReset();
    mBusy  = 1'b0;
    mOwner = 0;
    mLast  = NR - 1;
    mBeats = 0;
  endtask

  // One clock edge of the arbitration rules, using the inputs seen at the edge.
  task automatic modelEdge();
    int p;
    if (!mBusy) begin
      p = firstValid(req_valid, (mLast + 1) % NR);
      if (p >= 0) begin
        mBusy = 1'b1; mOwner = p; mLast = p; mBeats = 0;
      end
    end else begin
      if (req_valid[mOwner] && !wfull) mBeats++;
      if (mBeats == BU || !req_valid[mOwner]) begin
        p = firstValid(req_valid, (mOwner + 1) % NR);
        mBeats = 0;
        if (p >= 0) begin
          mOwner = p; mLast = p;
        end else begin
          mBusy = 1'b0;
        end
      end
    end
  endtask

  task automatic calcExp();
    expBusy  = mBusy;
    expReady = '0;
    expWinc  = 1'b0;
    expData  = '0;
    if (mBusy) begin
      if (req_valid[mOwner] && !wfull) begin
        expReady[mOwner] = 1'b1;
        expWinc          = 1'b1;
      end
      expData = req_data[mOwner*DS +: DS];
    end
  endtask

  // Advance one clock: model follows the edge, then step 1 unit past it.
  task automatic tick();
    @(posedge wclk);
    if (w_rst) modelReset(); else modelEdge();
    #1;
  endtask

  task automatic applyReset();
    w_rst = 1'b1; req_valid = '0; wfull = 1'b0; req_data = '0;
    tick(); tick();
    w_rst = 1'b0;
  endtask

  task automatic test_reset();
    w_rst = 1'b1; req_valid = 4'hF; wfull = 1'b0; req_data = $urandom;
    #1; modelReset();
    for (int c = 0; c < 2; c++) begin
      total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
      total++; if (winc !== 1'b0) begin bad++; $display("[TB] FAIL reset_winc: got %b want 0", winc); end
      total++; if (req_ready !== 4'b0) begin bad++; $display("[TB] FAIL reset_ready: got %b want 0000", req_ready); end
      total++; if (grant_id !== 2'd0) begin bad++; $display("[TB] FAIL reset_gid: got %0d want 0", grant_id); end
      total++; if (w_data !== 8'h00) begin bad++; $display("[TB] FAIL reset_wdata: got %h want 00", w_data); end
      tick();
    end
    w_rst = 1'b0;
  endtask

  task automatic test_single();
    applyReset();
    req_valid = 4'b0100; req_data = $urandom; #1;
    total++; if (winc !== 1'b0) begin bad++; $display("[TB] FAIL single_idle_winc: got %b want 0", winc); end
    tick(); #1;
    for (int k = 0; k < 9; k++) begin
      total++; if (grant_id !== 2'd2 || busy !== 1'b1) begin bad++; $display("[TB] FAIL single_gid: beat %0d got %0d/%b want 2/1", k, grant_id, busy); end
      total++; if (winc !== 1'b1) begin bad++; $display("[TB] FAIL single_winc: beat %0d got %b want 1", k, winc); end
      total++; if (w_data !== req_data[23:16]) begin bad++; $display("[TB] FAIL single_wdata: got %h want %h", w_data, req_data[23:16]); end
      tick(); req_data = $urandom; #1;
    end
  endtask

  task automatic test_all_valid();
    int order[5] = '{0, 1, 2, 3, 0};
    logic [NR-1:0] want;
    applyReset();
    req_valid = 4'hF; #1;
    tick(); #1;
    for (int k = 0; k < 20; k++) begin
      want = 4'b0001 << order[k/4];
      total++; if (grant_id !== 2'(order[k/4])) begin bad++; $display("[TB] FAIL all_order: cycle %0d got %0d want %0d", k, grant_id, order[k/4]); end
      total++; if (winc !== 1'b1) begin bad++; $display("[TB] FAIL all_winc: cycle %0d got %b want 1", k, winc); end
      total++; if (req_ready !== want) begin bad++; $display("[TB] FAIL all_ready: cycle %0d got %b want %b", k, req_ready, want); end
      tick(); #1;
    end
  endtask

  task automatic test_drop();
    applyReset();
    req_valid = 4'b1010; #1;
    tick(); #1;
    for (int k = 0; k < 2; k++) begin
      total++; if (grant_id !== 2'd1 || req_ready !== 4'b0010) begin bad++; $display("[TB] FAIL drop_pre: got gid %0d ready %b want 1/0010", grant_id, req_ready); end
      tick(); #1;
    end
    req_valid = 4'b1000; #1;
    total++; if (winc !== 1'b0 || req_ready !== 4'b0) begin bad++; $display("[TB] FAIL drop_cycle: got winc %b ready %b want 0/0000", winc, req_ready); end
    tick(); #1;
    for (int k = 0; k < 5; k++) begin
      total++; if (grant_id !== 2'd3 || winc !== 1'b1) begin bad++; $display("[TB] FAIL drop_next: cycle %0d got gid %0d winc %b want 3/1", k, grant_id, winc); end
      total++; if (req_ready[1] !== 1'b0) begin bad++; $display("[TB] FAIL drop_ready1: got %b want 0", req_ready[1]); end
      tick(); #1;
    end
  endtask

  task automatic test_wfull();
    applyReset();
    req_valid = 4'b0011; #1;
    tick(); #1;
    for (int k = 0; k < 2; k++) begin
      total++; if (grant_id !== 2'd0 || winc !== 1'b1) begin bad++; $display("[TB] FAIL full_pre: got gid %0d winc %b want 0/1", grant_id, winc); end
      tick(); #1;
    end
    wfull = 1'b1; #1;
    for (int k = 0; k < 5; k++) begin
      total++; if (winc !== 1'b0 || req_ready !== 4'b0) begin bad++; $display("[TB] FAIL full_stall: cycle %0d got winc %b ready %b want 0/0000", k, winc, req_ready); end
      total++; if (grant_id !== 2'd0 || busy !== 1'b1) begin bad++; $display("[TB] FAIL full_owner: got gid %0d busy %b want 0/1", grant_id, busy); end
      tick(); #1;
    end
    wfull = 1'b0; #1;
    for (int k = 0; k < 2; k++) begin
      total++; if (grant_id !== 2'd0 || winc !== 1'b1) begin bad++; $display("[TB] FAIL full_resume: beat %0d got gid %0d winc %b want 0/1", k, grant_id, winc); end
      tick(); #1;
    end
    total++; if (grant_id !== 2'd1 || winc !== 1'b1) begin bad++; $display("[TB] FAIL full_handover: got gid %0d winc %b want 1/1", grant_id, winc); end
  endtask

  task automatic test_reset_mid();
    applyReset();
    req_valid = 4'hF; #1;
    tick(); tick(); tick(); #1;
    total++; if (grant_id !== 2'd0 || winc !== 1'b1) begin bad++; $display("[TB] FAIL mid_pre: got gid %0d winc %b want 0/1", grant_id, winc); end
    w_rst = 1'b1; #1;
    modelReset();
    total++; if (busy !== 1'b0 || winc !== 1'b0) begin bad++; $display("[TB] FAIL mid_async: got busy %b winc %b want 0/0", busy, winc); end
    total++; if (req_ready !== 4'b0 || grant_id !== 2'd0) begin bad++; $display("[TB] FAIL mid_async_ready: got ready %b gid %0d want 0000/0", req_ready, grant_id); end
    tick();
    w_rst = 1'b0; #1;
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL mid_release: got busy %b want 0", busy); end
    tick(); #1;
    total++; if (grant_id !== 2'd0 || busy !== 1'b1 || winc !== 1'b1) begin bad++; $display("[TB] FAIL mid_first: got gid %0d busy %b winc %b want 0/1/1", grant_id, busy, winc); end
  endtask

  task automatic test_random();
    applyReset();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 2) == 0) req_valid = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) req_valid = '0;
      wfull    = ($urandom_range(0, 3) == 0);
      req_data = $urandom;
      #1;
      calcExp();
      total++; if (busy !== expBusy) begin bad++; $display("[TB] FAIL rnd_busy: cycle %0d got %b want %b", c, busy, expBusy); end
      total++; if (req_ready !== expReady) begin bad++; $display("[TB] FAIL rnd_ready: cycle %0d got %b want %b", c, req_ready, expReady); end
      total++; if (winc !== expWinc) begin bad++; $display("[TB] FAIL rnd_winc: cycle %0d got %b want %b", c, winc, expWinc); end
      total++; if (w_data !== expData) begin bad++; $display("[TB] FAIL rnd_wdata: cycle %0d got %h want %h", c, w_data, expData); end
      if (expBusy) begin
        total++; if (grant_id !== 2'(mOwner)) begin bad++; $display("[TB] FAIL rnd_gid: cycle %0d got %0d want %0d", c, grant_id, mOwner); end
      end
      if (wfull) begin
        total++; if (winc !== 1'b0) begin bad++; $display("[TB] FAIL rnd_full_winc: cycle %0d got %b want 0", c, winc); end
      end
      tick();
    end
  endtask

  initial begin
    w_rst = 1'b1; req_valid = '0; req_data = '0; wfull = 1'b0;
    modelReset();
    test_reset();
    test_single();
    test_all_valid();
    test_drop();
    test_wfull();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
